// File: rtl/wb_scoreboard_pkg.sv
// Shared scoreboard definitions: register address width and the rd_buf_flag
// encodings that identify a load, plus the decode helper built on them.
package wb_scoreboard_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int RD_BUF_FLAG_W  = 3;

  localparam logic [RD_BUF_FLAG_W-1:0] RD_BUF_LOAD_B = 3'd1;
  localparam logic [RD_BUF_FLAG_W-1:0] RD_BUF_LOAD_H = 3'd2;
  localparam logic [RD_BUF_FLAG_W-1:0] RD_BUF_LOAD_W = 3'd4;
  localparam logic [RD_BUF_FLAG_W-1:0] RD_BUF_LOAD_U = 3'd6;

  function automatic logic is_load_flag(input logic [RD_BUF_FLAG_W-1:0] flag);
    return (flag == RD_BUF_LOAD_B) || (flag == RD_BUF_LOAD_H) ||
           (flag == RD_BUF_LOAD_W) || (flag == RD_BUF_LOAD_U);
  endfunction

endpackage

// File: rtl/wb_scoreboard_sb_entry.sv
// One scoreboard entry: outstanding-write counter and newest-write-is-load bit
// for a single architectural register.
module sb_entry
  import wb_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             set_ld,
  input  logic             flush,
  output logic [CNT_W-1:0] cnt,
  output logic             ld
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ld_q, ld_d;

  always_comb begin
    cnt_d = cnt_q;
    ld_d  = ld_q;
    if (flush) begin
      cnt_d = '0;
      ld_d  = 1'b0;
    end else if (inc && dec) begin
      // one write retires while a newer one enters: count holds, newest type wins
      ld_d = set_ld;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
      ld_d  = set_ld;
    end else if (dec) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) ld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ld_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ld_q  <= ld_d;
    end
  end

  assign cnt = cnt_q;
  assign ld  = ld_q;

endmodule

// File: rtl/wb_scoreboard.sv
// Register-write scoreboard between decode and writeback: tracks in-flight
// writes per register and answers decode operand queries combinationally.
module wb_scoreboard
  import wb_scoreboard_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int AW     = REG_ADDR_WIDTH,
  parameter int CNT_W  = 2,
  parameter int FWD_EN = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  input  logic          issue_is_load,
  output logic          issue_ready,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_rd,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          rs1_load,
  output logic          rs2_load,
  output logic          stall,
  output logic          err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [NREGS];
  logic [NREGS-1:0] ld;
  logic             issue_acc;
  logic             wb_hit;
  logic             wb_eff;
  logic             wb_under;
  logic             err_q, err_d;

  // x0 is hardwired: never pending
  assign cnt[0] = '0;
  assign ld[0]  = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_entry
    sb_entry #(.CNT_W(CNT_W)) u_entry (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (issue_acc && (issue_rd == AW'(r))),
      .dec    (wb_eff && (wb_rd == AW'(r))),
      .set_ld (issue_is_load),
      .flush  (flush),
      .cnt    (cnt[r]),
      .ld     (ld[r])
    );
  end

  // A final writeback landing this cycle is bypassed so decode need not wait.
  function automatic logic op_busy(input logic [AW-1:0]    rs,
                                   input logic [CNT_W-1:0] c,
                                   input logic             wbv,
                                   input logic [AW-1:0]    wbr);
    return (rs != '0) && (c != '0) && !(wbv && (wbr == rs) && (c == CNT_W'(1)));
  endfunction

  assign issue_ready = (issue_rd == '0) || (cnt[issue_rd] != CNT_MAX);
  assign issue_acc   = issue_valid && issue_ready && (issue_rd != '0);
  assign wb_hit      = wb_valid && (wb_rd != '0);
  assign wb_eff      = wb_hit && (cnt[wb_rd] != '0);
  assign wb_under    = wb_hit && (cnt[wb_rd] == '0);

  assign rs1_busy = op_busy(rs1_addr, cnt[rs1_addr], wb_valid, wb_rd);
  assign rs2_busy = op_busy(rs2_addr, cnt[rs2_addr], wb_valid, wb_rd);
  assign rs1_load = rs1_busy && ld[rs1_addr];
  assign rs2_load = rs2_busy && ld[rs2_addr];

  assign stall = (id_valid && ((FWD_EN != 0) ? (rs1_load || rs2_load)
                                             : (rs1_busy || rs2_busy)))
               || (issue_valid && !issue_ready);

  always_comb begin
    err_d = err_q || wb_under;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_underflow = err_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Scenario bench for wb_scoreboard: one instance without and one with forwarding.
module tb_wb_scoreboard;
  import wb_scoreboard_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       issue_valid, issue_is_load, wb_valid, flush, id_valid;
  logic [4:0] issue_rd, wb_rd, rs1_addr, rs2_addr;

  logic rdy0, b1_0, b2_0, l1_0, l2_0, st0, err0;
  logic rdy1, b1_1, b2_1, l1_1, l2_1, st1, err1;

  always #5 clk = ~clk;

  wb_scoreboard #(.NREGS(32), .AW(5), .CNT_W(2), .FWD_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_is_load(issue_is_load), .issue_ready(rdy0), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .flush(flush), .id_valid(id_valid), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .rs1_busy(b1_0), .rs2_busy(b2_0), .rs1_load(l1_0),
    .rs2_load(l2_0), .stall(st0), .err_underflow(err0));

  wb_scoreboard #(.NREGS(32), .AW(5), .CNT_W(2), .FWD_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_is_load(issue_is_load), .issue_ready(rdy1), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .flush(flush), .id_valid(id_valid), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .rs1_busy(b1_1), .rs2_busy(b2_1), .rs1_load(l1_1),
    .rs2_load(l2_1), .stall(st1), .err_underflow(err1));

  typedef struct {
    string      nm;
    logic [7:0] v;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] obs_q[$];
  int         checks = 0;
  int         errors = 0;

  // Observation vector: {issue_ready, rs1_busy, rs2_busy, rs1_load, rs2_load,
  // stall(no fwd), stall(fwd), err_underflow}
  function automatic logic [7:0] observe();
    return {rdy0, b1_0, b2_0, l1_0, l2_0, st0, st1, err0};
  endfunction

  task automatic push_exp(input string nm, input logic [7:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    exp_q.push_back(e);
  endtask

  task automatic sample(input string nm, input logic [7:0] v);
    push_exp(nm, v);
    @(negedge clk);
    obs_q.push_back(observe());
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd = 0; issue_is_load = 0;
    wb_valid = 0; wb_rd = 0; flush = 0;
    id_valid = 0; rs1_addr = 0; rs2_addr = 0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [7:0] o;
    idle();
    id_valid = 1; rs1_addr = 5;
    sample("reset_query", 8'b1000_0000);
    step();
    rst_n = 1'b1;
    step();
    sample("post_reset_query", 8'b1000_0000);
    idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.nm, o, e.v); end
    end
  endtask

  task automatic test_basic();
    exp_t e;
    logic [7:0] o;
    step();
    issue_valid = 1; issue_rd = 5; id_valid = 1; rs1_addr = 5;
    sample("issue_same_cycle_not_busy", 8'b1000_0000);
    step();
    issue_valid = 0; issue_rd = 0;
    sample("busy_next_cycle", 8'b1100_0100);
    step();
    sample("busy_held", 8'b1100_0100);
    step();
    wb_valid = 1; wb_rd = 5;
    sample("wb_bypass", 8'b1000_0000);
    step();
    wb_valid = 0; wb_rd = 0;
    sample("cleared_after_wb", 8'b1000_0000);
    idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.nm, o, e.v); end
    end
  endtask

  task automatic test_fwd();
    exp_t e;
    logic [7:0] o;
    step();
    issue_valid = 1; issue_rd = 7; issue_is_load = is_load_flag(RD_BUF_LOAD_H);
    sample("issue_load7", 8'b1000_0000);
    step();
    issue_rd = 8; issue_is_load = is_load_flag(3'd0);
    id_valid = 1; rs2_addr = 7;
    sample("load_use_rs2", 8'b1010_1110);
    step();
    issue_valid = 0; issue_rd = 0; rs1_addr = 8; rs2_addr = 0;
    sample("alu_pending_fwd_no_stall", 8'b1100_0100);
    step();
    wb_valid = 1; wb_rd = 7; rs2_addr = 7;
    sample("wb7_bypass", 8'b1100_0100);
    step();
    wb_rd = 8; rs2_addr = 0;
    sample("wb8_bypass", 8'b1000_0000);
    idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.nm, o, e.v); end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    logic [7:0] o;
    for (int i = 0; i < 3; i++) begin
      step();
      issue_valid = 1; issue_rd = 3;
      sample($sformatf("fill3_%0d", i), 8'b1000_0000);
    end
    step();
    id_valid = 1; rs1_addr = 3;
    sample("saturated_issue", 8'b0100_0110);
    step();
    issue_valid = 0; wb_valid = 1; wb_rd = 3;
    sample("wb_cnt3_no_bypass", 8'b0100_0100);
    step();
    issue_valid = 1;
    sample("issue_wb_same_cnt2", 8'b1100_0100);
    step();
    wb_valid = 0;
    sample("issue_to_cnt3", 8'b1100_0100);
    step();
    issue_valid = 0; wb_valid = 1;
    sample("cnt3_again_ready0", 8'b0100_0100);
    step();
    sample("wb_cnt2", 8'b1100_0100);
    step();
    sample("wb_cnt1_bypass", 8'b1000_0000);
    step();
    wb_valid = 0;
    sample("cnt3_drained", 8'b1000_0000);
    idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.nm, o, e.v); end
    end
  endtask

  task automatic test_load_order();
    exp_t e;
    logic [7:0] o;
    step();
    issue_valid = 1; issue_rd = 10; issue_is_load = is_load_flag(RD_BUF_LOAD_W);
    sample("issue_load10", 8'b1000_0000);
    step();
    issue_is_load = is_load_flag(3'd3);
    id_valid = 1; rs1_addr = 10;
    sample("ld_newest_load", 8'b1101_0110);
    step();
    issue_is_load = is_load_flag(RD_BUF_LOAD_U);
    wb_valid = 1; wb_rd = 10;
    sample("ld_newest_alu", 8'b1100_0100);
    step();
    issue_valid = 0; issue_is_load = 0;
    sample("same_cycle_sets_ld", 8'b1101_0110);
    step();
    sample("last_wb_bypass", 8'b1000_0000);
    step();
    wb_valid = 0;
    sample("reg10_idle", 8'b1000_0000);
    idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.nm, o, e.v); end
    end
  endtask

  task automatic test_x0_underflow();
    exp_t e;
    logic [7:0] o;
    step();
    issue_valid = 1; issue_rd = 0; id_valid = 1; rs1_addr = 0;
    sample("issue_x0", 8'b1000_0000);
    step();
    issue_valid = 0;
    sample("x0_never_busy", 8'b1000_0000);
    step();
    wb_valid = 1; wb_rd = 9; rs1_addr = 9; issue_rd = 9;
    sample("underflow_cycle", 8'b1000_0000);
    step();
    wb_valid = 0;
    sample("underflow_sticky_state_kept", 8'b1000_0001);
    step();
    sample("underflow_still_set", 8'b1000_0001);
    idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.nm, o, e.v); end
    end
  endtask

  task automatic test_flush_reset();
    exp_t e;
    logic [7:0] o;
    step();
    issue_valid = 1; issue_rd = 4;
    sample("pend4", 8'b1000_0001);
    step();
    issue_rd = 6;
    sample("pend6", 8'b1000_0001);
    step();
    issue_rd = 4; flush = 1; id_valid = 1; rs1_addr = 4; rs2_addr = 6;
    sample("flush_cycle", 8'b1110_0101);
    step();
    issue_valid = 0; flush = 0;
    sample("after_flush", 8'b1000_0001);
    issue_valid = 1;
    step();
    issue_valid = 0; issue_rd = 0; rs2_addr = 0;
    #2;
    push_exp("pre_async_reset", 8'b1100_0101);
    obs_q.push_back(observe());
    rst_n = 1'b0;
    #1;
    push_exp("async_reset", 8'b1000_0000);
    obs_q.push_back(observe());
    step();
    step();
    rst_n = 1'b1;
    step();
    sample("after_reset_release", 8'b1000_0000);
    idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.nm, o, e.v); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fwd();
    test_saturate();
    test_load_order();
    test_x0_underflow();
    test_flush_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
